// File: rtl/sdram_pkg.sv
// Shared command encoding and mode-register decode for the SDRAM responder.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  localparam logic [2:0] CL_2 = 3'b010;
  localparam logic [2:0] CL_3 = 3'b011;

  // Extra read stages beyond the memory register; covers CL up to 3.
  localparam int PIPE_STAGES = 1;

  // Burst-length field (low two bits) to beat count: 1, 2, 4, 8.
  function automatic logic [3:0] bl_decode(input logic [1:0] f);
    return 4'd1 << f;
  endfunction

  // Only sequential bursts, BL codes 0..3 and CL 2/3 are supported.
  function automatic logic mode_ok(input logic [2:0] cl, input logic bl_hi, input logic bt);
    return !bl_hi && !bt && (cl == CL_2 || cl == CL_3);
  endfunction

endpackage

// File: rtl/sdram_rsp_mem.sv
// Backing store: one array per byte lane, byte-enabled write, 1-cycle registered read.
module sdram_rsp_mem #(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [BW-1:0] wbe,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int LW = DW / BW;

  logic [LW-1:0] rd_q [BW];

  for (genvar b = 0; b < BW; b++) begin : g_lane
    logic [LW-1:0] arr [2**AW];
    always_ff @(posedge clk) begin
      if (we && wbe[b]) arr[waddr] <= wdata[b*LW +: LW];
      if (re)           rd_q[b]    <= arr[raddr];
    end
  end

  always_comb begin
    rdata = '0;
    for (int b = 0; b < BW; b++) rdata[b*LW +: LW] = rd_q[b];
  end

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM model: bank/row tracking, mode register, burst engine,
// byte-masked storage and a CAS-latency read pipeline with protocol checking.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int BA_BITS   = 2,
  parameter int DQ_BITS   = 16,
  parameter int DQM_BITS  = 2,
  parameter int COL_BITS  = 9,
  parameter int MEM_AW    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdram_cke,
  input  logic                 sdram_cs_n,
  input  logic                 sdram_ras_n,
  input  logic                 sdram_cas_n,
  input  logic                 sdram_we_n,
  input  logic [BA_BITS-1:0]   sdram_ba,
  input  logic [ADDR_BITS-1:0] sdram_addr,
  input  logic [DQM_BITS-1:0]  sdram_dqm,
  input  logic [DQ_BITS-1:0]   dq_i,
  output logic [DQ_BITS-1:0]   dq_o,
  output logic                 dq_oe,
  output logic                 proto_err
);
  localparam int NBANK = 2**BA_BITS;

  cmd_e                 cmd;
  logic [NBANK-1:0]     bank_open;
  logic [ADDR_BITS-1:0] bank_row [NBANK];
  logic [3:0]           mode_bl;
  logic                 mode_cl3, mode_wsingle;

  logic                 burst_act, burst_rd;
  logic [3:0]           burst_len, beat_idx;
  logic [BA_BITS-1:0]   burst_ba;
  logic [COL_BITS-1:0]  burst_col;

  logic [PIPE_STAGES:0] vld_pipe;
  logic [DQ_BITS-1:0]   data_q1, mem_rdata, out_data;
  logic                 dqm_q, out_vld;

  logic                 bank_hit, busy, err, rd_go, wr_go;
  logic [3:0]           new_len;
  logic                 beat_go, beat_wr;
  logic [BA_BITS-1:0]   beat_ba;
  logic [COL_BITS-1:0]  beat_col, blk_mask;
  logic [MEM_AW-1:0]    mem_idx;

  always_comb cmd = sdram_cs_n ? CMD_NOP : cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});

  assign bank_hit = bank_open[sdram_ba];
  assign busy     = (|bank_open) | burst_act | (|vld_pipe) | dq_oe;

  always_comb begin
    err = 1'b0;
    if (sdram_cke) begin
      case (cmd)
        CMD_READ, CMD_WRITE: err = !bank_hit;
        CMD_ACT:             err = bank_hit;
        CMD_REF:             err = busy;
        CMD_MRS:             err = busy || !mode_ok(sdram_addr[6:4], sdram_addr[2], sdram_addr[3]);
        default:             err = 1'b0;
      endcase
    end
  end

  assign rd_go   = sdram_cke && cmd == CMD_READ  && bank_hit;
  assign wr_go   = sdram_cke && cmd == CMD_WRITE && bank_hit;
  assign new_len = (wr_go && mode_wsingle) ? 4'd1 : mode_bl;

  // Sequential burst wraps inside the BL-aligned column block.
  assign blk_mask = COL_BITS'(burst_len - 4'd1);

  always_comb begin
    beat_go  = 1'b0;
    beat_wr  = 1'b0;
    beat_ba  = burst_ba;
    beat_col = (burst_col & ~blk_mask) | ((burst_col + COL_BITS'(beat_idx)) & blk_mask);
    if (rd_go || wr_go) begin
      beat_go  = 1'b1;
      beat_wr  = wr_go;
      beat_ba  = sdram_ba;
      beat_col = sdram_addr[COL_BITS-1:0];
    end else if (sdram_cke && burst_act && cmd != CMD_BST) begin
      beat_go = 1'b1;
      beat_wr = !burst_rd;
    end
  end

  assign mem_idx = MEM_AW'({beat_ba, bank_row[beat_ba], beat_col});

  sdram_rsp_mem #(.AW(MEM_AW), .DW(DQ_BITS), .BW(DQM_BITS)) u_mem (
    .clk   (clk),
    .we    (beat_go && beat_wr),
    .waddr (mem_idx),
    .wdata (dq_i),
    .wbe   (~sdram_dqm),
    .re    (beat_go && !beat_wr),
    .raddr (mem_idx),
    .rdata (mem_rdata)
  );

  // Bank table and mode register; offending commands are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open    <= '0;
      mode_bl      <= 4'd1;
      mode_cl3     <= 1'b0;
      mode_wsingle <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      proto_err <= err;
      if (sdram_cke && !err) begin
        case (cmd)
          CMD_ACT: bank_open[sdram_ba] <= 1'b1;
          CMD_PRE: begin
            if (sdram_addr[10]) bank_open <= '0;
            else                bank_open[sdram_ba] <= 1'b0;
          end
          CMD_MRS: begin
            mode_bl      <= bl_decode(sdram_addr[1:0]);
            mode_cl3     <= sdram_addr[6:4] == CL_3;
            mode_wsingle <= sdram_addr[9];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sdram_cke && cmd == CMD_ACT && !bank_hit) bank_row[sdram_ba] <= sdram_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_act <= 1'b0;
      burst_rd  <= 1'b0;
      burst_len <= 4'd1;
      beat_idx  <= 4'd0;
      burst_ba  <= '0;
      burst_col <= '0;
    end else if (sdram_cke) begin
      if (rd_go || wr_go) begin
        burst_act <= new_len > 4'd1;
        burst_rd  <= rd_go;
        burst_len <= new_len;
        beat_idx  <= 4'd1;
        burst_ba  <= sdram_ba;
        burst_col <= sdram_addr[COL_BITS-1:0];
      end else if (burst_act) begin
        if (cmd == CMD_BST) begin
          burst_act <= 1'b0;
        end else begin
          beat_idx <= beat_idx + 4'd1;
          if (beat_idx == burst_len - 4'd1) burst_act <= 1'b0;
        end
      end
    end
  end

  assign out_vld  = mode_cl3 ? vld_pipe[1] : vld_pipe[0];
  assign out_data = mode_cl3 ? data_q1 : mem_rdata;

  // Read DQM is registered once here and applied on the following edge: latency 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dqm_q    <= 1'b0;
      dq_oe    <= 1'b0;
      dq_o     <= '0;
    end else if (sdram_cke) begin
      dqm_q <= |sdram_dqm;
      if (wr_go) begin
        vld_pipe <= '0;
        dq_oe    <= 1'b0;
      end else begin
        vld_pipe <= {vld_pipe[PIPE_STAGES-1:0], beat_go && !beat_wr};
        data_q1  <= mem_rdata;
        dq_oe    <= out_vld && !dqm_q;
        if (out_vld) dq_o <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench: stimulus pushes expected read beats, a negedge monitor pops and compares.
module tb_sdram_responder;

  localparam logic [2:0] C_MRS = 3'b000, C_PRE = 3'b010, C_ACT = 3'b011,
                         C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

  logic        clk, rst;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_dqm;
  logic [15:0] dq_i, dq_o;
  logic        dq_oe, proto_err;

  int tests = 0, fails = 0;
  int oe_cnt = 0, oe_starts = 0, err_cnt = 0;
  logic oe_prev = 1'b0;
  logic [15:0] exp_q [$];

  sdram_responder dut (
    .clk(clk), .rst(rst), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm),
    .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The controller consumes a beat at an edge only when cke is high there.
  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      oe_cnt++;
      if (!oe_prev) oe_starts++;
    end
    oe_prev = (dq_oe === 1'b1);
    if (proto_err === 1'b1) err_cnt++;
    if (dq_oe === 1'b1 && sdram_cke) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_beat: unexpected beat %h", dq_o);
      end else begin
        chk("rd_beat", {16'h0, dq_o}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [1:0] ba = 2'd0, input logic [12:0] a = 13'd0,
                       input logic [15:0] d = 16'h0, input logic [1:0] m = 2'b00);
    sdram_cs_n = 1'b0;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba = ba; sdram_addr = a; dq_i = d; sdram_dqm = m;
    @(posedge clk); #1;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    sdram_dqm = 2'b00; dq_i = 16'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(C_NOP);
  endtask

  // Called right after a READ edge: dq_oe must first appear at READ edge + cl.
  task automatic rd_latency(input string name, input int cl);
    repeat (cl - 1) @(negedge clk);
    chk({name, "_oe_early"}, {31'h0, dq_oe}, 32'h0);
    @(negedge clk);
    chk({name, "_oe_first"}, {31'h0, dq_oe}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sdram_cke = 1'b1; sdram_cs_n = 1'b1;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    sdram_ba = '0; sdram_addr = '0; sdram_dqm = '0; dq_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dq_oe", {31'h0, dq_oe}, 32'h0);
    chk("rst_dq_o", {16'h0, dq_o}, 32'h0);
    chk("rst_proto_err", {31'h0, proto_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // BL=1 CL=2 single write/read
    issue(C_MRS, 0, 13'h020);
    issue(C_ACT, 1, 13'h005);
    issue(C_WR, 1, 13'd3, 16'hBEEF);
    idle(1);
    oe_cnt = 0;
    exp_q.push_back(16'hBEEF);
    issue(C_RD, 1, 13'd3);
    rd_latency("t1", 2);
    idle(4);
    chk("t1_oe_cycles", oe_cnt, 1);
    chk("t1_no_err", err_cnt, 0);

    // BL=4 CL=3 wrapping burst
    issue(C_PRE, 0, 13'h400);
    idle(2);
    issue(C_MRS, 0, 13'h032);
    issue(C_ACT, 1, 13'h005);
    issue(C_WR, 1, 13'd6, 16'h1111);
    issue(C_NOP, 0, 0, 16'h2222);
    issue(C_NOP, 0, 0, 16'h3333);
    issue(C_NOP, 0, 0, 16'h4444);
    idle(1);
    oe_cnt = 0;
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    issue(C_RD, 1, 13'd4);
    rd_latency("t2", 3);
    idle(6);
    chk("t2_oe_cycles", oe_cnt, 4);

    // byte-masked write, BST, read DQM masking beat 2
    issue(C_WR, 1, 13'd8, 16'h1234);
    issue(C_NOP, 0, 0, 16'h5555);
    issue(C_NOP, 0, 0, 16'h6666);
    issue(C_NOP, 0, 0, 16'h7777);
    idle(1);
    issue(C_WR, 1, 13'd8, 16'hAAAA, 2'b01);
    issue(C_BST);
    idle(1);
    oe_cnt = 0;
    exp_q.push_back(16'hAA34); exp_q.push_back(16'h5555); exp_q.push_back(16'h7777);
    issue(C_RD, 1, 13'd8);
    idle(2);
    issue(C_NOP, 0, 0, 16'h0, 2'b11);
    idle(6);
    chk("t3_oe_cycles", oe_cnt, 3);

    // protocol errors leave state untouched; back-to-back reads are gapless
    oe_cnt = 0;
    issue(C_RD, 2, 13'd4);
    @(negedge clk);
    chk("t4_err_pulse", {31'h0, proto_err}, 32'h1);
    @(posedge clk); #1;
    issue(C_ACT, 1, 13'h007);
    idle(3);
    chk("t4_err_count", err_cnt, 2);
    chk("t4_no_oe", oe_cnt, 0);
    oe_cnt = 0; oe_starts = 0;
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'hAA34); exp_q.push_back(16'h5555);
    exp_q.push_back(16'h6666); exp_q.push_back(16'h7777);
    issue(C_RD, 1, 13'd4);
    idle(3);
    issue(C_RD, 1, 13'd8);
    idle(10);
    chk("t4_oe_cycles", oe_cnt, 8);
    chk("t4_gapless", oe_starts, 1);

    // BL=8 CL=3, invalid MRS rejected, clock suspend mid-burst
    issue(C_PRE, 0, 13'h400);
    idle(1);
    issue(C_MRS, 0, 13'h033);
    issue(C_MRS, 0, 13'h024);
    idle(2);
    chk("t5_bad_mrs_err", err_cnt, 3);
    issue(C_ACT, 1, 13'h005);
    for (int i = 0; i < 8; i++)
      issue(i == 0 ? C_WR : C_NOP, 1, 13'd16, 16'h8000 + 16'(i));
    idle(1);
    oe_cnt = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h8000 + 16'(i));
    issue(C_RD, 1, 13'd16);
    idle(4);
    sdram_cke = 1'b0;
    idle(3);
    sdram_cke = 1'b1;
    idle(10);
    chk("t5_suspend_oe_cycles", oe_cnt, 11);
    chk("t5_q_empty", exp_q.size(), 0);

    // reset mid-burst after beat 5
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h8000 + 16'(i));
    issue(C_RD, 1, 13'd16);
    idle(7);
    rst = 1'b1;
    idle(1);
    @(negedge clk);
    chk("t5_rst_oe", {31'h0, dq_oe}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    chk("t5_rst_q_empty", exp_q.size(), 0);

    // after reset: banks closed, BL=1 CL=2, storage kept
    issue(C_RD, 1, 13'd16);
    idle(2);
    chk("t6_closed_err", err_cnt, 4);
    issue(C_ACT, 1, 13'h005);
    exp_q.push_back(16'h8000);
    oe_cnt = 0;
    issue(C_RD, 1, 13'd16);
    rd_latency("t6", 2);
    idle(4);
    chk("t6_oe_cycles", oe_cnt, 1);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
